// File: rtl/node_dispatch_arbiter_pkg.sv
// Shared definitions for the node dispatch arbiter: enable codes, FSM states,
// destination decode and round-robin pointer advance.
package node_dispatch_arbiter_pkg;

   localparam logic [1:0] EN_SELF  = 2'b01;
   localparam logic [1:0] EN_LEFT  = 2'b00;
   localparam logic [1:0] EN_RIGHT = 2'b10;
   localparam logic [1:0] EN_IDLE  = 2'b11;

   localparam int DEST_BITS = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   // Unsigned compare against the node address; equal always means self.
   function automatic logic [1:0] decode_dest(input logic [7:0] dest, input logic [7:0] node);
      logic [1:0] code;
      if (dest == node) begin
         code = EN_SELF;
      end else if (dest < node) begin
         code = EN_LEFT;
      end else begin
         code = EN_RIGHT;
      end
      return code;
   endfunction

   function automatic logic [1:0] next_ptr(input logic [2:0] owner);
      logic [1:0] ptr;
      case (owner)
         3'b001:  ptr = 2'd1;
         3'b010:  ptr = 2'd2;
         3'b100:  ptr = 2'd0;
         default: ptr = 2'd0;
      endcase
      return ptr;
   endfunction

endpackage

// File: rtl/node_dispatch_arbiter_rr_arbiter3.sv
// Three-way combinational round-robin picker: search starts at ptr and wraps.
module rr_arbiter3
   import node_dispatch_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic [2:0] gnt
);

   // Priority rotates with ptr; ptr=3 is unreachable and treated like 0.
   always_comb begin
      gnt = 3'b000;
      case (ptr)
         2'd1: begin
            if (req[1])      gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else             gnt = 3'b000;
         end
         2'd2: begin
            if (req[2])      gnt = 3'b100;
            else if (req[0]) gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else             gnt = 3'b000;
         end
         default: begin
            if (req[0])      gnt = 3'b001;
            else if (req[1]) gnt = 3'b010;
            else if (req[2]) gnt = 3'b100;
            else             gnt = 3'b000;
         end
      endcase
   end

endmodule

// File: rtl/node_dispatch_arbiter.sv
// Shares the node's master dispatch datapath between local core, left link and
// right link; one round-robin grant per transaction, released on ack or timeout.
module node_dispatch_arbiter
   import node_dispatch_arbiter_pkg::*;
#(
   parameter int         WIDTH     = 32,
   parameter logic [7:0] NODE_ADDR = 8'h00,
   parameter int         TIMEOUT   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       req_valid,
   input  logic [WIDTH-1:0] req_instr0,
   input  logic [WIDTH-1:0] req_instr1,
   input  logic [WIDTH-1:0] req_instr2,
   output logic [2:0]       req_ready,
   input  logic             check_self,
   input  logic             check_left,
   input  logic             check_right,
   output logic [1:0]       enable,
   output logic [WIDTH-1:0] out_instr,
   output logic [2:0]       grant,
   output logic             busy,
   output logic             done,
   output logic             timeout_err
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t           r_state;
   logic [1:0]       r_rr_ptr;
   logic [WIDTH-1:0] r_instr;
   logic [1:0]       r_dest_code;
   logic [7:0]       r_cnt;

   logic [2:0]       w_gnt;
   logic [WIDTH-1:0] w_sel_instr;
   logic             w_ack;

   rr_arbiter3 u_rr (
      .req (req_valid),
      .ptr (r_rr_ptr),
      .gnt (w_gnt)
   );

   // Ready is only offered while idle and out of reset, so no transfer can slip through either.
   always_comb begin
      if ((r_state == S_IDLE) && !reset) begin
         req_ready = w_gnt;
      end else begin
         req_ready = 3'b000;
      end
   end

   // Instruction of the round-robin winner.
   always_comb begin
      case (w_gnt)
         3'b001:  w_sel_instr = req_instr0;
         3'b010:  w_sel_instr = req_instr1;
         3'b100:  w_sel_instr = req_instr2;
         default: w_sel_instr = '0;
      endcase
   end

   // Only the check line matching the latched destination can end WAIT.
   always_comb begin
      case (r_dest_code)
         EN_SELF:  w_ack = check_self;
         EN_LEFT:  w_ack = check_left;
         EN_RIGHT: w_ack = check_right;
         default:  w_ack = 1'b0;
      endcase
   end

   // Transaction FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= 2'd0;
         r_instr     <= '0;
         r_dest_code <= EN_IDLE;
         r_cnt       <= 8'd0;
         enable      <= EN_IDLE;
         out_instr   <= '0;
         grant       <= 3'b000;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|w_gnt) begin
                  r_instr     <= w_sel_instr;
                  r_dest_code <= decode_dest(w_sel_instr[WIDTH-1 -: DEST_BITS], NODE_ADDR);
                  grant       <= w_gnt;
                  busy        <= 1'b1;
                  r_state     <= S_ISSUE;
               end else begin
                  r_state     <= S_IDLE;
               end
            end
            S_ISSUE: begin
               enable    <= r_dest_code;
               out_instr <= r_instr;
               r_cnt     <= 8'd0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               // Ack wins over timeout when both land on the last allowed cycle.
               if (w_ack) begin
                  enable  <= EN_IDLE;
                  done    <= 1'b1;
                  r_state <= S_DRAIN;
               end else if (r_cnt == TO_LAST) begin
                  enable      <= EN_IDLE;
                  done        <= 1'b1;
                  timeout_err <= 1'b1;
                  r_state     <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DRAIN: begin
               done     <= 1'b0;
               grant    <= 3'b000;
               busy     <= 1'b0;
               r_rr_ptr <= next_ptr(grant);
               r_state  <= S_IDLE;
            end
            default: begin
               enable  <= EN_IDLE;
               grant   <= 3'b000;
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
